fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of one `asyn_fifo` among NREQ requesters in the FIFO write-clock domain. Each requester gets a burst: up to MAX_BURST words, or fewer if it ends the burst with `I_last`. Backpressure comes from the FIFO's `O_wfull`. The block sits between the producer engines and the `asyn_fifo` write port (`I_winc`/`I_wdata`/`O_wfull`).

---
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port
// among NREQ producers in the FIFO write-clock domain.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic [NREQ-1:0]       I_req,
  input  logic [NREQ-1:0]       I_valid,
  input  logic [NREQ-1:0]       I_last,
  input  logic [NREQ*DSIZE-1:0] I_data,
  output logic [NREQ-1:0]       O_ready,
  output logic [NREQ-1:0]       O_grant,
  output logic                  O_winc,
  output logic [DSIZE-1:0]      O_wdata,
  input  logic                  I_wfull,
  output logic                  O_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_nxt;
  logic [PW-1:0]   g_idx;
  logic [PW-1:0]   jj;
  logic [BW-1:0]   bcnt;
  logic [BW-1:0]   bcnt_nxt;
  logic            found;
  logic            xfer;
  logic            own_last;
  logic            own_req;
  logic            cap;
  logic            burst_end;

  // first requester at or above rr_ptr, wrapping
  always_comb begin
    pick_oh = '0;
    found   = 1'b0;
    jj      = '0;
    for (int i = 0; i < NREQ; i++) begin
      jj = PW'((int'(rr_ptr) + i) % NREQ);
      if (!found && I_req[jj]) begin
        pick_oh[jj] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (O_grant[i]) g_idx = PW'(i);
    end
  end

  // zero grant selects zero data
  always_comb begin
    O_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (O_grant[k]) begin
        O_wdata = O_wdata | I_data[k*DSIZE +: DSIZE];
      end
    end
  end

  assign O_busy  = (state == BURST);
  assign O_ready = (O_busy && !I_wfull) ? O_grant : '0;
  assign xfer    = |(I_valid & O_ready);
  assign O_winc  = xfer;

  assign own_last  = |(I_last & O_grant);
  assign own_req   = |(I_req & O_grant);
  assign cap       = (bcnt == BW'(MAX_BURST - 1));
  assign burst_end = (xfer & (own_last | cap))
                   | (~own_req & ~xfer);

  always_comb begin
    state_nxt = state;
    grant_nxt = O_grant;
    rr_nxt    = rr_ptr;
    bcnt_nxt  = bcnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick_oh;
          bcnt_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          bcnt_nxt  = '0;
          rr_nxt    = (g_idx == PW'(NREQ - 1))
                    ? '0 : g_idx + PW'(1);
        end else if (xfer) begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= IDLE;
      O_grant <= '0;
      rr_ptr  <= '0;
      bcnt    <= '0;
    end else begin
      state   <= state_nxt;
      O_grant <= grant_nxt;
      rr_ptr  <= rr_nxt;
      bcnt    <= bcnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues, FIFO occupancy
// model and a burst-level round-robin reference.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int MAXB  = 16;
  localparam int DEPTH = 1024;
  localparam int MEMSZ = 2048;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       I_req = '0;
  logic [NREQ-1:0]       I_valid = '0;
  logic [NREQ-1:0]       I_last = '0;
  logic [NREQ*DSIZE-1:0] I_data = '0;
  logic [NREQ-1:0]       O_ready;
  logic [NREQ-1:0]       O_grant;
  logic                  O_winc;
  logic [DSIZE-1:0]      O_wdata;
  logic                  I_wfull = 1'b0;
  logic                  O_busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAXB)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_req(I_req), .I_valid(I_valid),
    .I_last(I_last), .I_data(I_data),
    .O_ready(O_ready), .O_grant(O_grant),
    .O_winc(O_winc), .O_wdata(O_wdata),
    .I_wfull(I_wfull), .O_busy(O_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] dmem [NREQ][MEMSZ];
  bit         lmem [NREQ][MEMSZ];
  int         head [NREQ];
  int         tail [NREQ];
  bit         en   [NREQ];
  int         vpct, rpct, occ, cyc;
  logic [NREQ-1:0] last_grant;

  logic [7:0] got[$];
  int         gotcyc[$];
  int         bursts[$];
  logic [7:0] exp_d[$];
  int         exp_b[$];

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push_word(input int k, input logic [7:0] d,
                           input bit l);
    dmem[k][tail[k]] = d;
    lmem[k][tail[k]] = l;
    tail[k]++;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NREQ; k++) begin
      head[k] = 0; tail[k] = 0; en[k] = 1'b1;
    end
    occ = 0; cyc = 0; last_grant = '0;
    vpct = 100; rpct = 100;
    got.delete(); gotcyc.delete(); bursts.delete();
  endtask

  task automatic apply_reset();
    I_req = '0; I_valid = '0; I_last = '0; I_data = '0;
    I_wfull = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // burst-level reference: who owns each burst and word order
  task automatic build_model();
    int h[NREQ];
    int p, g, n;
    exp_d.delete(); exp_b.delete();
    for (int k = 0; k < NREQ; k++) h[k] = head[k];
    p = 0;
    forever begin
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (p + i) % NREQ;
        if (g < 0 && en[k] && h[k] < tail[k]) g = k;
      end
      if (g < 0) break;
      exp_b.push_back(g);
      n = 0;
      forever begin
        exp_d.push_back(dmem[g][h[g]]);
        n++; h[g]++;
        if (lmem[g][h[g]-1] || n == MAXB || h[g] == tail[g]) break;
      end
      p = (g + 1) % NREQ;
    end
  endtask

  // one cycle: drive at negedge, sample, commit at posedge
  task automatic step();
    bit wr, rd, av;
    int src;
    logic [7:0] wd;
    for (int k = 0; k < NREQ; k++) begin
      av = en[k] && head[k] < tail[k];
      I_req[k]   = av;
      I_valid[k] = av && ($urandom_range(0, 99) < vpct);
      I_last[k]  = av ? lmem[k][head[k]] : 1'b0;
      I_data[k*DSIZE +: DSIZE] =
        av ? dmem[k][head[k]] : DSIZE'($urandom);
    end
    I_wfull = (occ >= DEPTH);
    #1;
    if (I_wfull) begin
      checks++;
      if (O_winc !== 1'b0 || O_ready !== '0) begin
        errors++;
        $display("FAIL full_hold winc=%b ready=%b want 0/0",
                 O_winc, O_ready);
      end
    end
    wr = O_winc;
    if (wr) begin
      checks++;
      if (O_ready !== O_grant || oh_idx(O_grant) < 0) begin
        errors++;
        $display("FAIL ready_vs_grant ready=%b want %b",
                 O_ready, O_grant);
      end
    end
    if (O_grant != '0 && last_grant == '0)
      bursts.push_back(oh_idx(O_grant));
    last_grant = O_grant;
    wd  = O_wdata;
    src = oh_idx(O_ready);
    rd  = occ > 0 && ($urandom_range(0, 99) < rpct);
    @(posedge clk);
    if (wr) begin
      got.push_back(wd);
      gotcyc.push_back(cyc);
      if (src >= 0) head[src]++;
    end
    occ = occ + int'(wr) - int'(rd);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int maxc);
    int n;
    bit pend;
    n = 0;
    forever begin
      pend = 1'b0;
      for (int k = 0; k < NREQ; k++)
        if (en[k] && head[k] < tail[k]) pend = 1'b1;
      if (!pend) break;
      if (n >= maxc) begin
        checks++; errors++;
        $display("FAIL timeout cycles=%0d want <%0d", n, maxc);
        break;
      end
      step();
      n++;
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    I_req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({O_grant, O_ready, O_winc, O_busy, O_wdata} !== '0) begin
        errors++;
        $display("FAIL reset_outs g=%b r=%b w=%b b=%b d=%h want 0",
                 O_grant, O_ready, O_winc, O_busy, O_wdata);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (O_grant !== '0) begin
      errors++;
      $display("FAIL pre_grant got=%b want 0000", O_grant);
    end
    @(posedge clk);
    #1;
    checks++;
    if (O_grant !== 4'b0001 || O_busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant got=%b busy=%b want 0001/1",
               O_grant, O_busy);
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < NREQ; k++) begin
      push_word(k, 8'(k * 16 + 1), 1'b0);
      push_word(k, 8'(k * 16 + 2), 1'b1);
    end
    run(100);
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL rr_count got=%0d want 8", got.size());
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      logic [7:0] e;
      e = 8'((i / 2) * 16 + (i % 2) + 1);
      checks++;
      if (got[i] !== e) begin
        errors++;
        $display("FAIL rr_word[%0d] got=%h want %h", i, got[i], e);
      end
    end
    for (int i = 0; i < bursts.size() || i < 4; i++) begin
      checks++;
      if (i >= bursts.size() || i >= 4 || bursts[i] != i) begin
        errors++;
        $display("FAIL rr_grant[%0d] got=%0d want %0d", i,
                 (i < bursts.size()) ? bursts[i] : -1, i);
      end
    end
    for (int i = 0; i + 1 < gotcyc.size(); i++) begin
      int e;
      e = (i % 2 == 0) ? 1 : 2;
      checks++;
      if (gotcyc[i+1] - gotcyc[i] != e) begin
        errors++;
        $display("FAIL rr_gap[%0d] got=%0d want %0d", i,
                 gotcyc[i+1] - gotcyc[i], e);
      end
    end
  endtask

  task automatic test_max_burst();
    apply_reset();
    for (int i = 1; i <= 30; i++) push_word(1, 8'(i), i == 30);
    run(200);
    checks++;
    if (got.size() != 30) begin
      errors++;
      $display("FAIL cap_count got=%0d want 30", got.size());
    end
    for (int i = 0; i < got.size() && i < 30; i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL cap_word[%0d] got=%h want %h",
                 i, got[i], 8'(i + 1));
      end
    end
    checks++;
    if (bursts.size() != 2 || bursts[0] != 1 || bursts[1] != 1) begin
      errors++;
      $display("FAIL cap_bursts got=%0d want 2 bursts of 1",
               bursts.size());
    end
    for (int i = 0; i + 1 < gotcyc.size(); i++) begin
      int e;
      e = (i == 15) ? 2 : 1;
      checks++;
      if (gotcyc[i+1] - gotcyc[i] != e) begin
        errors++;
        $display("FAIL cap_gap[%0d] got=%0d want %0d", i,
                 gotcyc[i+1] - gotcyc[i], e);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      for (int k = 0; k < NREQ; k++) begin
        int n;
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++)
          push_word(k, 8'($urandom),
                    (i == n - 1) || ($urandom_range(0, 4) == 0));
      end
      vpct = $urandom_range(40, 100);
      rpct = 100;
      build_model();
      run(2000);
      checks++;
      if (got.size() != exp_d.size()) begin
        errors++;
        $display("FAIL rnd_count it=%0d got=%0d want %0d",
                 it, got.size(), exp_d.size());
      end
      for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
        checks++;
        if (got[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL rnd_word it=%0d [%0d] got=%h want %h",
                   it, i, got[i], exp_d[i]);
        end
      end
      checks++;
      if (bursts != exp_b) begin
        errors++;
        $display("FAIL rnd_bursts it=%0d got=%0d want %0d bursts",
                 it, bursts.size(), exp_b.size());
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 1040; i++)
      push_word(0, 8'(i * 7 + 3), i == 1039);
    vpct = 100;
    rpct = 0;
    build_model();
    repeat (1150) step();
    checks++;
    if (got.size() != DEPTH || occ != DEPTH) begin
      errors++;
      $display("FAIL fill got=%0d occ=%0d want %0d",
               got.size(), occ, DEPTH);
    end
    checks++;
    if (O_grant !== 4'b0001) begin
      errors++;
      $display("FAIL hold_grant got=%b want 0001", O_grant);
    end
    rpct = 50;
    run(3000);
    checks++;
    if (got.size() != exp_d.size()) begin
      errors++;
      $display("FAIL bp_count got=%0d want %0d",
               got.size(), exp_d.size());
    end
    for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL bp_word[%0d] got=%h want %h",
                 i, got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] e [7];
    int n;
    apply_reset();
    for (int i = 0; i < 10; i++) push_word(2, 8'(8'h20 + i), 1'b0);
    push_word(0, 8'h00, 1'b0); push_word(0, 8'h01, 1'b1);
    push_word(3, 8'h30, 1'b0); push_word(3, 8'h31, 1'b1);
    en[0] = 1'b0; en[1] = 1'b0; en[3] = 1'b0;
    n = 0;
    while (got.size() < 3 && n < 20) begin
      step(); n++;
    end
    en[0] = 1'b1; en[3] = 1'b1; en[2] = 1'b0;
    step();
    #1;
    checks++;
    if (O_grant !== '0 || O_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear got=%b busy=%b want 0000/0",
               O_grant, O_busy);
    end
    @(negedge clk);
    step();
    #1;
    checks++;
    if (O_grant !== 4'b1000) begin
      errors++;
      $display("FAIL abort_next got=%b want 1000", O_grant);
    end
    @(negedge clk);
    run(100);
    e = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h00, 8'h01};
    checks++;
    if (got.size() != 7) begin
      errors++;
      $display("FAIL abort_count got=%0d want 7", got.size());
    end
    for (int i = 0; i < got.size() && i < 7; i++) begin
      checks++;
      if (got[i] !== e[i]) begin
        errors++;
        $display("FAIL abort_word[%0d] got=%h want %h",
                 i, got[i], e[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    for (int i = 0; i < 10; i++) push_word(0, 8'(8'h50 + i), i == 9);
    n = 0;
    while (got.size() < 4 && n < 20) begin
      step(); n++;
    end
    #1;
    checks++;
    if (O_winc !== 1'b1) begin
      errors++;
      $display("FAIL word5_winc got=%b want 1", O_winc);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (O_winc !== 1'b0 || O_grant !== '0 ||
        O_ready !== '0 || O_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst w=%b g=%b r=%b b=%b want 0",
               O_winc, O_grant, O_ready, O_busy);
    end
    I_req = '0; I_valid = '0; I_last = '0;
    @(negedge clk);
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL no_partial got=%0d want 4", got.size());
    end
    rst_n = 1'b1;
    clear_model();
    for (int k = 0; k < NREQ; k++) push_word(k, 8'(k), 1'b1);
    step();
    #1;
    checks++;
    if (O_grant !== 4'b0001) begin
      errors++;
      $display("FAIL rst_regrant got=%b want 0001", O_grant);
    end
    @(negedge clk);
    run(100);
  endtask

  initial begin
    clear_model();
    test_reset();
    test_round_robin();
    test_max_burst();
    test_random();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
